// File: rtl/rv_packer_pkg.sv
// rv_packer_pkg: shared constants, lane type and final-beat helper for rv_byte_packer.
// Contents: RV_PACKER_MAX_RATIO, lane_t, is_final().
package rv_packer_pkg;
    localparam int RV_PACKER_MAX_RATIO = 16;
    typedef logic [$clog2(RV_PACKER_MAX_RATIO)-1:0] lane_t;
    function automatic logic is_final(input lane_t lane, input int ratio, input logic last);
        return (int'(lane) == ratio - 1) | last;
    endfunction
endpackage

// File: rtl/rv_byte_packer_if.sv
// rv_byte_packer_if: byte-in / word-out ready/valid bundle for rv_byte_packer.
// Signals: input_port_{data,valid,ready}, output_port_{data,valid,ready};
// input_port_last and output_port_bytes only when RV_PACKER_FLUSH_EN is defined.
// Modports: master = producer/consumer side (testbench), slave = packer side.
interface rv_byte_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO = 4
);
    logic [DATA_WIDTH-1:0]       input_port_data;
    logic                        input_port_valid;
    logic                        input_port_ready;
    logic [DATA_WIDTH*RATIO-1:0] output_port_data;
    logic                        output_port_valid;
    logic                        output_port_ready;
`ifdef RV_PACKER_FLUSH_EN
    logic                        input_port_last;
    logic [$clog2(RATIO):0]      output_port_bytes;
    modport master (
        output input_port_data, input_port_valid, input_port_last, output_port_ready,
        input  input_port_ready, output_port_data, output_port_valid, output_port_bytes
    );
    modport slave (
        input  input_port_data, input_port_valid, input_port_last, output_port_ready,
        output input_port_ready, output_port_data, output_port_valid, output_port_bytes
    );
`else
    modport master (
        output input_port_data, input_port_valid, output_port_ready,
        input  input_port_ready, output_port_data, output_port_valid
    );
    modport slave (
        input  input_port_data, input_port_valid, output_port_ready,
        output input_port_ready, output_port_data, output_port_valid
    );
`endif
endinterface

// File: rtl/rv_packer_logic.sv
// rv_packer_logic: control half of rv_byte_packer (lane counter, output valid flag,
// input ready and load/write enables).
// Ports: clock_port, reset_port (sync, active-low), in_valid_i, in_last_i, out_ready_i,
// in_ready_o, out_valid_o, load_o (final beat accepted), wr_o (non-final beat accepted), lane_o.
module rv_packer_logic
    import rv_packer_pkg::*;
#(
    parameter int RATIO = 4
) (
    input  logic  clock_port,
    input  logic  reset_port,
    input  logic  in_valid_i,
    input  logic  in_last_i,
    input  logic  out_ready_i,
    output logic  in_ready_o,
    output logic  out_valid_o,
    output logic  load_o,
    output logic  wr_o,
    output lane_t lane_o
);
    lane_t lane_q, lane_d;
    logic  valid_q, valid_d, fin, acc;
    // Only a word-closing beat needs the output register, so only it can stall.
    always_comb begin
        fin        = is_final(lane_q, RATIO, in_last_i);
        in_ready_o = reset_port & (~fin | ~valid_q | out_ready_i);
        acc        = in_valid_i & in_ready_o;
        load_o     = acc & fin;
        wr_o       = acc & ~fin;
        lane_d     = load_o ? '0 : acc ? lane_t'(lane_q + 1'b1) : lane_q;
        valid_d    = load_o | (valid_q & ~out_ready_i);
    end
    always_ff @(posedge clock_port) begin
        if (!reset_port) begin
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            valid_q <= valid_d;
        end
    end
    assign out_valid_o = valid_q;
    assign lane_o      = lane_q;
endmodule

// File: rtl/rv_byte_packer.sv
// rv_byte_packer: packs RATIO consecutive DATA_WIDTH beats (little-endian lanes) into one registered word.
// Ports: clock_port, reset_port (sync, active-low), bus (rv_byte_packer_if.slave).
// Optional feature macro: RV_PACKER_FLUSH_EN adds input_port_last / output_port_bytes partial words.
module rv_byte_packer
    import rv_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO = 4
) (
    input logic              clock_port,
    input logic              reset_port,
    rv_byte_packer_if.slave  bus
);
    localparam int WW = DATA_WIDTH * RATIO;
    lane_t                              lane;
    logic                               last, load, wr;
    logic [DATA_WIDTH*(RATIO-1)-1:0]    asm_q, asm_d;
    logic [WW-1:0]                      asm_x, out_q, out_d;
`ifdef RV_PACKER_FLUSH_EN
    assign last = bus.input_port_last;
`else
    assign last = 1'b0;
`endif
    rv_packer_logic #(.RATIO(RATIO)) u_logic (
        .clock_port  (clock_port),
        .reset_port  (reset_port),
        .in_valid_i  (bus.input_port_valid),
        .in_last_i   (last),
        .out_ready_i (bus.output_port_ready),
        .in_ready_o  (bus.input_port_ready),
        .out_valid_o (bus.output_port_valid),
        .load_o      (load),
        .wr_o        (wr),
        .lane_o      (lane)
    );
    // Zero top lane so the load mux can index RATIO lanes uniformly.
    assign asm_x = {{DATA_WIDTH{1'b0}}, asm_q};
    // On load: lanes below the current lane come from assembly, the current lane is the
    // incoming beat, lanes above are zero (only reachable on an early last beat).
    always_comb begin
        asm_d = asm_q;
        out_d = out_q;
        if (wr)
            asm_d[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = bus.input_port_data;
        if (load)
            for (int i = 0; i < RATIO; i++)
                out_d[i*DATA_WIDTH +: DATA_WIDTH] = (i < int'(lane)) ? asm_x[i*DATA_WIDTH +: DATA_WIDTH] :
                                                    (i == int'(lane)) ? bus.input_port_data : '0;
    end
    always_ff @(posedge clock_port) begin
        if (!reset_port) begin
            asm_q <= '0;
            out_q <= '0;
        end else begin
            asm_q <= asm_d;
            out_q <= out_d;
        end
    end
    assign bus.output_port_data = out_q;
`ifdef RV_PACKER_FLUSH_EN
    localparam int BW = $clog2(RATIO) + 1;
    logic [BW-1:0] bytes_q;
    always_ff @(posedge clock_port) begin
        if (!reset_port)
            bytes_q <= '0;
        else if (load)
            bytes_q <= BW'(int'(lane) + 1);
    end
    assign bus.output_port_bytes = bytes_q;
`endif
endmodule
